// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing unit.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_VEC = 2'b10;
    localparam logic [1:0] PCSEL_EPC = 2'b11;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID-stage sources and the EX-stage load.
module hazard_detect (
    input  logic [5:0] rs_num,
    input  logic [5:0] rt_num,
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic       ex_ld,
    input  logic       ex_regwrite,
    input  logic [5:0] ex_write,
    output logic       hazard
);

    logic load_dest;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_dest = ex_ld & ex_regwrite & (ex_write != 6'd0);
    assign hazard    = load_dest & ((uses_rs & (rs_num == ex_write)) |
                                    (uses_rt & (rt_num == ex_write)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stall/flush controls, next-PC select, interrupt drain and halt FSM,
// plus saturating bubble/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_rs_num,
    input  logic [5:0]       id_rt_num,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_ld,
    input  logic             ex_regwrite,
    input  logic [5:0]       ex_write,
    input  logic             branch_taken,
    input  logic             eret,
    input  logic             int_req,
    input  logic             int_en,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_zero,
    output logic             idex_zero,
    output logic [1:0]       pc_sel,
    output logic             epc_we,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_bubble,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               hazard;
    logic               take_int;
    logic               bubble_inc;
    logic               flush_inc;

    hazard_detect u_hazard_detect (
        .rs_num      (id_rs_num),
        .rt_num      (id_rt_num),
        .uses_rs     (id_uses_rs),
        .uses_rt     (id_uses_rt),
        .ex_ld       (ex_ld),
        .ex_regwrite (ex_regwrite),
        .ex_write    (ex_write),
        .hazard      (hazard)
    );

    assign take_int = int_req & int_en;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        ifid_zero  = 1'b0;
        idex_zero  = 1'b0;
        pc_sel     = PCSEL_SEQ;
        epc_we     = 1'b0;
        halted     = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;

        if (rst) begin
            // Hold the pipe frozen and cleared for as long as reset is asserted.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            ifid_zero = 1'b1;
            idex_zero = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        pc_sel    = PCSEL_BR;
                        ifid_zero = 1'b1;
                        idex_zero = 1'b1;
                        flush_inc = 1'b1;
                    end else if (eret) begin
                        pc_sel    = PCSEL_EPC;
                        ifid_zero = 1'b1;
                        idex_zero = 1'b1;
                        flush_inc = 1'b1;
                    end else if (halt_req) begin
                        state_d   = ST_HALT;
                        idex_zero = 1'b1;
                    end else if (take_int) begin
                        state_d   = ST_DRAIN;
                        drain_d   = DRAIN_LOAD;
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_zero = 1'b1;
                    end else if (hazard) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_zero  = 1'b1;
                        bubble_inc = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_zero = 1'b1;
                    if (drain_q == '0) begin
                        state_d = ST_ENTER;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                ST_ENTER: begin
                    pc_sel    = PCSEL_VEC;
                    epc_we    = 1'b1;
                    ifid_zero = 1'b1;
                    idex_zero = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = ST_RUN;
                end
                ST_HALT: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    halted  = 1'b1;
                    if (take_int) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else if (resume) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_bubble <= '0;
            cnt_flush  <= '0;
        end else begin
            if (bubble_inc && (cnt_bubble != '1)) begin
                cnt_bubble <= cnt_bubble + CNT_W'(1);
            end
            if (flush_inc && (cnt_flush != '1)) begin
                cnt_flush <= cnt_flush + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned CNT_W        = 4;
    localparam int SAT = (1 << CNT_W) - 1;
    localparam int M_RUN = 0, M_DRAIN = 1, M_ENTER = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       id_rs_num, id_rt_num, ex_write;
    logic             id_uses_rs, id_uses_rt, ex_ld, ex_regwrite;
    logic             branch_taken, eret, int_req, int_en, halt_req, resume;
    logic             pc_en, ifid_en, idex_en, ifid_zero, idex_zero, epc_we, halted;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] cnt_bubble, cnt_flush;

    int nvec = 0;
    int nerr = 0;

    // Model state: mode, DRAIN cycles still to spend, event counts.
    int m_mode, m_left, m_bub, m_fl;
    int n_mode, n_left;
    bit inc_b, inc_f;
    logic e_pc_en, e_ifid_en, e_idex_en, e_ifid_zero, e_idex_zero, e_epc_we, e_halted;
    logic [1:0] e_pc_sel;

    pipeline_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs_num    (id_rs_num),
        .id_rt_num    (id_rt_num),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_ld        (ex_ld),
        .ex_regwrite  (ex_regwrite),
        .ex_write     (ex_write),
        .branch_taken (branch_taken),
        .eret         (eret),
        .int_req      (int_req),
        .int_en       (int_en),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .ifid_zero    (ifid_zero),
        .idex_zero    (idex_zero),
        .pc_sel       (pc_sel),
        .epc_we       (epc_we),
        .halted       (halted),
        .cnt_bubble   (cnt_bubble),
        .cnt_flush    (cnt_flush)
    );

    always #5 clk = ~clk;

    function automatic bit spec_hazard();
        if (!(ex_ld && ex_regwrite) || ex_write == 6'd0) return 1'b0;
        return (id_uses_rs && id_rs_num == ex_write) || (id_uses_rt && id_rt_num == ex_write);
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_left = 0; m_bub = 0; m_fl = 0;
        n_mode = M_RUN; n_left = 0; inc_b = 0; inc_f = 0;
    endtask

    task automatic model_eval();
        e_pc_en = 1; e_ifid_en = 1; e_idex_en = 1; e_ifid_zero = 0; e_idex_zero = 0;
        e_pc_sel = 2'b00; e_epc_we = 0; e_halted = 0;
        n_mode = m_mode; n_left = m_left; inc_b = 0; inc_f = 0;
        case (m_mode)
            M_RUN: begin
                if (branch_taken) begin
                    e_pc_sel = 2'b01; e_ifid_zero = 1; e_idex_zero = 1; inc_f = 1;
                end else if (eret) begin
                    e_pc_sel = 2'b11; e_ifid_zero = 1; e_idex_zero = 1; inc_f = 1;
                end else if (halt_req) begin
                    n_mode = M_HALT; e_idex_zero = 1;
                end else if (int_req && int_en) begin
                    n_mode = M_DRAIN; n_left = DRAIN_CYCLES;
                    e_pc_en = 0; e_ifid_en = 0; e_idex_zero = 1;
                end else if (spec_hazard()) begin
                    e_pc_en = 0; e_ifid_en = 0; e_idex_zero = 1; inc_b = 1;
                end
            end
            M_DRAIN: begin
                e_pc_en = 0; e_ifid_en = 0; e_idex_zero = 1;
                if (m_left <= 1) n_mode = M_ENTER;
                else n_left = m_left - 1;
            end
            M_ENTER: begin
                e_pc_sel = 2'b10; e_epc_we = 1; e_ifid_zero = 1; e_idex_zero = 1; inc_f = 1;
                n_mode = M_RUN;
            end
            default: begin
                e_pc_en = 0; e_ifid_en = 0; e_idex_en = 0; e_halted = 1;
                if (int_req && int_en) begin
                    n_mode = M_DRAIN; n_left = DRAIN_CYCLES;
                end else if (resume) begin
                    n_mode = M_RUN;
                end
            end
        endcase
    endtask

    task automatic model_step();
        m_mode = n_mode; m_left = n_left;
        if (inc_b && m_bub < SAT) m_bub++;
        if (inc_f && m_fl < SAT) m_fl++;
        inc_b = 0; inc_f = 0;
    endtask

    task automatic clear_inputs();
        id_rs_num = 0; id_rt_num = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_ld = 0; ex_regwrite = 0; ex_write = 0;
        branch_taken = 0; eret = 0; int_req = 0; int_en = 0; halt_req = 0; resume = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        nvec++;
        if ({pc_en, ifid_en, idex_en, ifid_zero, idex_zero, pc_sel, epc_we, halted} !== 9'b000110000)
        begin
            nerr++;
            $display("FAIL reset_outputs got %b want 000110000",
                     {pc_en, ifid_en, idex_en, ifid_zero, idex_zero, pc_sel, epc_we, halted});
        end
        nvec++;
        if (cnt_bubble !== '0 || cnt_flush !== '0) begin
            nerr++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_bubble, cnt_flush);
        end
        @(negedge clk);
        rst = 1'b0;
        settle();
        nvec++;
        if ({pc_en, ifid_en, idex_en, ifid_zero, idex_zero} !== 5'b11100) begin
            nerr++;
            $display("FAIL run_defaults got %b want 11100",
                     {pc_en, ifid_en, idex_en, ifid_zero, idex_zero});
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_ld = 1; ex_regwrite = 1; ex_write = 6'd8; id_rs_num = 6'd8; id_uses_rs = 1;
        settle();
        nvec++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_zero !== 1'b1 || ifid_zero !== 1'b0) begin
            nerr++;
            $display("FAIL load_use_stall pc_en,ifid_en,idex_zero,ifid_zero got %b%b%b%b want 0010",
                     pc_en, ifid_en, idex_zero, ifid_zero);
        end
        tick();
        ex_ld = 0;
        settle();
        nvec++;
        if (pc_en !== 1'b1 || cnt_bubble !== CNT_W'(m_bub) || m_bub != 1) begin
            nerr++;
            $display("FAIL load_use_one_bubble pc_en=%b cnt_bubble=%0d want pc_en=1 cnt_bubble=1",
                     pc_en, cnt_bubble);
        end
        tick();
        ex_ld = 1; ex_write = 6'd0; id_rs_num = 6'd0;
        settle();
        nvec++;
        if (pc_en !== 1'b1 || idex_zero !== 1'b0) begin
            nerr++;
            $display("FAIL load_r0_no_stall pc_en,idex_zero got %b%b want 10", pc_en, idex_zero);
        end
        tick();
        settle();
        nvec++;
        if (cnt_bubble !== CNT_W'(1)) begin
            nerr++;
            $display("FAIL load_r0_no_count cnt_bubble got %0d want 1", cnt_bubble);
        end
        tick();
    endtask

    task automatic test_branch_hazard();
        clear_inputs();
        ex_ld = 1; ex_regwrite = 1; ex_write = 6'd5; id_rt_num = 6'd5; id_uses_rt = 1;
        branch_taken = 1;
        settle();
        nvec++;
        if (pc_sel !== 2'b01 || ifid_zero !== 1'b1 || idex_zero !== 1'b1 || pc_en !== 1'b1) begin
            nerr++;
            $display("FAIL branch_over_hazard pc_sel=%b zeros=%b%b pc_en=%b want 01 11 1",
                     pc_sel, ifid_zero, idex_zero, pc_en);
        end
        tick();
        clear_inputs();
        settle();
        nvec++;
        if (cnt_flush !== CNT_W'(1) || cnt_bubble !== CNT_W'(1)) begin
            nerr++;
            $display("FAIL branch_counts flush/bubble got %0d/%0d want 1/1", cnt_flush, cnt_bubble);
        end
        tick();
        eret = 1;
        settle();
        nvec++;
        if (pc_sel !== 2'b11 || ifid_zero !== 1'b1 || idex_zero !== 1'b1) begin
            nerr++;
            $display("FAIL eret_redirect pc_sel=%b zeros=%b%b want 11 11", pc_sel, ifid_zero, idex_zero);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_interrupt();
        int pulses;
        int pulse_at;
        bit leave;
        clear_inputs();
        int_req = 1;
        settle();
        nvec++;
        if (pc_en !== 1'b1 || idex_zero !== 1'b0) begin
            nerr++;
            $display("FAIL int_masked pc_en,idex_zero got %b%b want 10", pc_en, idex_zero);
        end
        tick();
        int_en = 1;
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < 6; i++) begin
            settle();
            nvec++;
            if ({pc_en, ifid_en, ifid_zero, idex_zero, pc_sel, epc_we} !==
                {e_pc_en, e_ifid_en, e_ifid_zero, e_idex_zero, e_pc_sel, e_epc_we}) begin
                nerr++;
                $display("FAIL int_seq cycle %0d got %b want %b", i,
                         {pc_en, ifid_en, ifid_zero, idex_zero, pc_sel, epc_we},
                         {e_pc_en, e_ifid_en, e_ifid_zero, e_idex_zero, e_pc_sel, e_epc_we});
            end
            if (epc_we === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            leave = (m_mode == M_ENTER);
            tick();
            if (leave) int_req = 0;
        end
        nvec++;
        if (pulses != 1 || pulse_at != int'(DRAIN_CYCLES) + 1) begin
            nerr++;
            $display("FAIL int_latency epc pulses=%0d at=%0d want 1 at %0d",
                     pulses, pulse_at, DRAIN_CYCLES + 1);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        clear_inputs();
        halt_req = 1;
        settle();
        tick();
        halt_req = 0;
        branch_taken = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            nvec++;
            if ({halted, pc_en, ifid_en, idex_en, ifid_zero, idex_zero} !== 6'b100000) begin
                nerr++;
                $display("FAIL halt_frozen cycle %0d got %b want 100000", i,
                         {halted, pc_en, ifid_en, idex_en, ifid_zero, idex_zero});
            end
            tick();
        end
        branch_taken = 0;
        resume = 1;
        settle();
        tick();
        resume = 0;
        settle();
        nvec++;
        if (halted !== 1'b0 || pc_en !== 1'b1) begin
            nerr++;
            $display("FAIL halt_resume halted,pc_en got %b%b want 01", halted, pc_en);
        end
        tick();
        halt_req = 1;
        settle();
        tick();
        halt_req = 0;
        int_req = 1; int_en = 1; resume = 1;
        settle();
        tick();
        resume = 0;
        settle();
        nvec++;
        if (halted !== 1'b0 || pc_en !== 1'b0 || idex_zero !== 1'b1 || m_mode != M_DRAIN) begin
            nerr++;
            $display("FAIL halt_int_to_drain halted,pc_en,idex_zero got %b%b%b want 001",
                     halted, pc_en, idex_zero);
        end
        while (m_mode != M_ENTER) begin
            tick();
            settle();
        end
        nvec++;
        if (epc_we !== 1'b1 || pc_sel !== 2'b10) begin
            nerr++;
            $display("FAIL halt_int_enter epc_we,pc_sel got %b %b want 1 10", epc_we, pc_sel);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rst_mid_drain();
        clear_inputs();
        int_req = 1; int_en = 1;
        settle();
        tick();
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if ({pc_en, ifid_en, idex_en, ifid_zero, idex_zero, pc_sel, epc_we, halted} !== 9'b000110000
            || cnt_bubble !== '0 || cnt_flush !== '0) begin
            nerr++;
            $display("FAIL rst_mid_drain got %b cnt %0d/%0d want 000110000 cnt 0/0",
                     {pc_en, ifid_en, idex_en, ifid_zero, idex_zero, pc_sel, epc_we, halted},
                     cnt_bubble, cnt_flush);
        end
        model_reset();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            nvec++;
            if (epc_we !== 1'b0 || pc_en !== 1'b1 || pc_sel !== 2'b00) begin
                nerr++;
                $display("FAIL rst_abort_no_enter cycle %0d epc_we,pc_en,pc_sel got %b%b%b want 0100",
                         i, epc_we, pc_en, pc_sel);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        clear_inputs();
        ex_ld = 1; ex_regwrite = 1; ex_write = 6'd3; id_rs_num = 6'd3; id_uses_rs = 1;
        for (int i = 0; i < SAT + 3; i++) begin
            settle();
            tick();
        end
        settle();
        nvec++;
        if (cnt_bubble !== {CNT_W{1'b1}} || m_bub != SAT) begin
            nerr++;
            $display("FAIL bubble_saturate got %0d want %0d", cnt_bubble, SAT);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [8:0] got, want;
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            id_rs_num    = 6'($urandom_range(0, 3));
            id_rt_num    = 6'($urandom_range(0, 3));
            ex_write     = 6'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_ld        = 1'($urandom_range(0, 1));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            eret         = ($urandom_range(0, 11) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            int_req      = ($urandom_range(0, 9) == 0);
            int_en       = 1'($urandom_range(0, 1));
            resume       = ($urandom_range(0, 3) == 0);
            settle();
            got  = {pc_en, ifid_en, idex_en, ifid_zero, idex_zero, pc_sel, epc_we, halted};
            want = {e_pc_en, e_ifid_en, e_idex_en, e_ifid_zero, e_idex_zero, e_pc_sel, e_epc_we,
                    e_halted};
            nvec++;
            if (got !== want) begin
                nerr++;
                $display("FAIL rand_ctrl cycle %0d got %b want %b", i, got, want);
            end
            nvec++;
            if (cnt_bubble !== CNT_W'(m_bub) || cnt_flush !== CNT_W'(m_fl)) begin
                nerr++;
                $display("FAIL rand_counters cycle %0d got %0d/%0d want %0d/%0d",
                         i, cnt_bubble, cnt_flush, m_bub, m_fl);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_interrupt();
        test_halt();
        test_rst_mid_drain();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing unit for the five-stage interrupt-capable core. It generates the per-stage enable and zero (flush) controls for PC, IF/ID and ID/EX, and selects the next-PC source. It detects load-use hazards, applies branch/jump/eret redirects, and runs the interrupt-entry drain sequence and the syscall halt state. It also keeps saturating bubble/flush performance counters.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles spent in DRAIN before handler entry (≥1)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs_num, id_rt_num  in  6 each  source register numbers of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_ld  in  1  instruction in EX is a load
- ex_regwrite  in  1  EX instruction writes the register file
- ex_write  in  6  EX destination register number
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- eret  in  1  eret resolved in EX this cycle
- int_req  in  1  level interrupt request; held by source until serviced
- int_en  in  1  global interrupt enable from CP0
- halt_req  in  1  syscall halt resolved in EX
- resume  in  1  external resume pulse
- pc_en  out  1  PC register load enable
- ifid_en, idex_en  out  1 each  stage register enables; idex_en drives ID/EX stall/enable input
- ifid_zero, idex_zero  out  1 each  stage register synchronous clear; zero overrides enable
- pc_sel  out  2  00 PC+4, 01 branch target, 10 handler vector, 11 EPC
- epc_we  out  1  capture the ID-stage PC into CP0 EPC
- halted  out  1  core frozen in HALT
- cnt_bubble, cnt_flush  out  CNT_W each  saturating event counters

## Operation
- States: RUN, DRAIN, ENTER, HALT. The state register and drain counter are clocked. The control outputs are Mealy-combinational from the state and current inputs.
- Load-use hazard condition: ex_ld & ex_regwrite & ex_write≠0 & ((id_uses_rs & id_rs_num==ex_write) | (id_uses_rt & id_rt_num==ex_write)).
- Default RUN outputs: pc_en=ifid_en=idex_en=1, zeros=0, pc_sel=00, epc_we=0.
- RUN priority, highest first:
  1. branch_taken: pc_sel=01, ifid_zero=idex_zero=1, cnt_flush+1.
  2. eret: pc_sel=11, ifid_zero=idex_zero=1, cnt_flush+1.
  3. halt_req: next HALT; idex_zero=1.
  4. int_req&int_en: next DRAIN, drain counter loaded with DRAIN_CYCLES-1; pc_en=ifid_en=0, idex_zero=1.
  5. load-use hazard: pc_en=ifid_en=0, idex_zero=1 (one bubble), cnt_bubble+1.
- A deferred interrupt is taken on the first RUN cycle with no higher-priority event, because int_req is a level signal.
- DRAIN: pc_en=ifid_en=0, idex_zero=1. The counter decrements each cycle; at 0 the next state is ENTER.
- ENTER (exactly one cycle): pc_en=1, pc_sel=10, epc_we=1, ifid_zero=idex_zero=1, cnt_flush+1. Next state is RUN.
- HALT: pc_en=ifid_en=idex_en=0, zeros=0, halted=1.
  - resume: next RUN.
  - int_req&int_en: next DRAIN. This has priority over resume.
- Counters saturate at all-ones and never wrap.

## Timing
- rst high, asynchronously: state=RUN, drain counter=0, counters=0. While rst is held: pc_en=ifid_en=idex_en=0, ifid_zero=idex_zero=1, pc_sel=00, epc_we=0, halted=0.
- Hazard and redirect controls take effect at the same clock edge they are evaluated on (zero latency).
- The load-use bubble is exactly one cycle. On the next cycle the load is in MEM, so the condition clears.
- Interrupt latency from accepting int_req to handler fetch: DRAIN_CYCLES + 1 cycles.
- branch_taken arriving with a load-use hazard: the branch wins and no bubble is counted.
- branch_taken or eret arriving during DRAIN/ENTER/HALT is ignored. Upstream has already been frozen or flushed.
- rst mid-DRAIN aborts the sequence: no epc_we pulse, and the core returns to RUN.

## Structure
- Package pipeline_ctrl_pkg: state enum (RUN, DRAIN, ENTER, HALT) and pc_sel constants (PCSEL_SEQ, PCSEL_BR, PCSEL_VEC, PCSEL_EPC).
- Sub-module hazard_detect: purely combinational load-use compare. It is reused by the forwarding unit.
- Top level contains the FSM, drain counter, and two saturating counters.

## Test plan
- Load-use: ex_ld=1, ex_regwrite=1, ex_write=8, id_rs_num=8, id_uses_rs=1 → one cycle with pc_en=0, idex_zero=1; cnt_bubble=1. Repeat with ex_write=0 → no stall.
- Branch plus hazard in the same cycle → pc_sel=01, ifid_zero=idex_zero=1, cnt_flush=1, cnt_bubble unchanged.
- Interrupt with int_en=1, DRAIN_CYCLES=2 → 2 DRAIN cycles, then one ENTER cycle with pc_sel=10 and epc_we=1, then RUN. With int_en=0 → no reaction.
- halt_req → halted=1 and all enables 0 for 5 cycles; resume pulse → RUN next cycle. Repeat with int_req during HALT → DRAIN.
- rst asserted mid-DRAIN (asynchronous, between edges) → outputs immediately go to reset values; epc_we never pulses.
- Force cnt_bubble to all-ones, then apply a further hazard → value stays all-ones.
